// File: rtl/aes_mem_arbiter.sv
// Two-master (CPU / AES engine) arbiter onto a single-port 32-bit on-chip RAM with 1-cycle read latency.
// Define AES_MEM_ARB_FIXED_PRIO_EN to give master 1 fixed priority; default is round robin.
module aes_mem_arbiter #(
  parameter int          ADDR_W   = 15,
  parameter int          DEPTH    = 25000,
  parameter logic [31:0] OOR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic              w_req0;
  logic              w_req1;
  logic              w_grant;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_acc;
  logic              w_acc_rd;
  logic              w_acc_wr;
  logic              w_in_range;
  logic              w_sel_read;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [3:0]        w_sel_be;
  logic [31:0]       w_sel_wdata;
  logic [31:0]       w_rdata;

  logic              r_tag_valid;
  logic              r_tag_id;
  logic              r_tag_oor;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

`ifdef AES_MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant = 1'b0;
    if (w_req1) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end
`else
  logic r_last_grant;

  // Under contention the master that did not win last time gets the port.
  always_comb begin
    w_grant = 1'b0;
    if (w_req0 && w_req1) begin
      w_grant = ~r_last_grant;
    end else if (w_req1) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_acc) begin
      r_last_grant <= w_grant;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  always_comb begin
    w_sel_read  = 1'b0;
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_be    = 4'b0000;
    w_sel_wdata = 32'h0000_0000;
    if (w_grant) begin
      w_sel_read  = m1_read;
      w_sel_write = m1_write;
      w_sel_addr  = m1_address;
      w_sel_be    = m1_byteenable;
      w_sel_wdata = m1_writedata;
    end else begin
      w_sel_read  = m0_read;
      w_sel_write = m0_write;
      w_sel_addr  = m0_address;
      w_sel_be    = m0_byteenable;
      w_sel_wdata = m0_writedata;
    end
  end

  assign w_acc0     = w_req0 & ~w_grant;
  assign w_acc1     = w_req1 & w_grant;
  assign w_acc      = w_acc0 | w_acc1;
  // A simultaneous read+write strobe is a write; it never produces read data.
  assign w_acc_wr   = w_acc & w_sel_write;
  assign w_acc_rd   = w_acc & w_sel_read & ~w_sel_write;
  assign w_in_range = 32'(w_sel_addr) < DEPTH_W;

  assign m0_waitrequest = w_req0 & ~w_acc0;
  assign m1_waitrequest = w_req1 & ~w_acc1;

  assign ram_address    = w_sel_addr;
  assign ram_byteenable = w_sel_be;
  assign ram_writedata  = w_sel_wdata;
  assign ram_chipselect = w_acc & w_in_range;
  assign ram_write      = w_acc_wr;
  assign ram_clken      = ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_valid <= 1'b0;
      r_tag_id    <= 1'b0;
      r_tag_oor   <= 1'b0;
    end else begin
      r_tag_valid <= w_acc_rd;
      r_tag_id    <= w_grant;
      r_tag_oor   <= ~w_in_range;
    end
  end

  // RAM q is only meaningful in the cycle after the read; OOR reads never touched the RAM.
  assign w_rdata          = r_tag_oor ? OOR_DATA : ram_readdata;
  assign m0_readdatavalid = r_tag_valid & ~r_tag_id;
  assign m1_readdatavalid = r_tag_valid & r_tag_id;
  assign m0_readdata      = m0_readdatavalid ? w_rdata : 32'h0000_0000;
  assign m1_readdata      = m1_readdatavalid ? w_rdata : 32'h0000_0000;

endmodule
